// File: rtl/tick_gen_multi_if.sv
// rtl/tick_gen_multi_if.sv - control/status bundle between the switch side and the tick generator
//
// Purpose: carries the asynchronous pause/speed controls into the tick
// generator and its per-channel tick, square-wave and paused status back out.
//
// Signals:
//   pause    switch side -> generator   pause level, asynchronous
//   speed    switch side -> generator   speed select level, asynchronous
//   tick     generator -> switch side   1-cycle pulse per channel period
//   clk_out  generator -> switch side   per-channel square wave, toggles on tick
//   paused   generator -> switch side   synchronised pause state
//
// Modports:
//   master   the side that drives pause/speed and consumes the ticks
//   slave    the tick generator itself

interface tick_gen_multi_if #(
    parameter int NUM_CH  = 3,
    parameter int SPEED_W = 2
);
    logic                pause;
    logic [SPEED_W-1:0]  speed;
    logic [NUM_CH-1:0]   tick;
    logic [NUM_CH-1:0]   clk_out;
    logic                paused;

    modport master (
        output pause,
        output speed,
        input  tick,
        input  clk_out,
        input  paused
    );

    modport slave (
        input  pause,
        input  speed,
        output tick,
        output clk_out,
        output paused
    );
endinterface

// File: rtl/tick_gen_multi.sv
// rtl/tick_gen_multi.sv - N-channel tick / clock-enable generator with speed scaling and pause
//
// Purpose: each channel divides clk_50m by a compile-time divisor and emits a
// registered 1-cycle tick plus a 50%-duty square wave toggling on every tick.
// Channels flagged in SPEED_MASK have their divisor shifted right by the
// synchronised speed select; channels flagged in PAUSE_MASK freeze while the
// synchronised pause is high.
//
// Ports:
//   clk_50m   in   system clock
//   rst       in   asynchronous reset, active low
//   bus       slave modport of tick_gen_multi_if:
//               pause, speed            asynchronous control levels
//               tick[NUM_CH]            1-cycle pulse per channel period
//               clk_out[NUM_CH]         square wave, toggles on each tick
//               paused                  synchronised pause state
//
// Parameters:
//   NUM_CH      number of channels
//   CNT_W       counter / divisor width per channel
//   SPEED_W     width of the speed select
//   DIV_VEC     packed divisors, channel 0 in the LSBs
//   SPEED_MASK  bit i set: channel i divisor is scaled by speed
//   PAUSE_MASK  bit i set: channel i is frozen while paused

module tick_gen_multi #(
    parameter int                         NUM_CH     = 3,
    parameter int                         CNT_W      = 26,
    parameter int                         SPEED_W    = 2,
    parameter logic [NUM_CH*CNT_W-1:0]    DIV_VEC    = {26'd6250000, 26'd50000000, 26'd1},
    parameter logic [NUM_CH-1:0]          SPEED_MASK = 3'b100,
    parameter logic [NUM_CH-1:0]          PAUSE_MASK = 3'b110
) (
    input  logic              clk_50m,
    input  logic              rst,
    tick_gen_multi_if.slave   bus
);

    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    // ------------------------------------------------------------------
    // Two-stage synchronisers for the switch inputs. speed_prev trails
    // speed_s by one cycle so a change is seen for exactly one cycle.
    // ------------------------------------------------------------------
    logic               pause_m;
    logic               pause_s;
    logic [SPEED_W-1:0] speed_m;
    logic [SPEED_W-1:0] speed_s;
    logic [SPEED_W-1:0] speed_prev;
    logic               speed_chg;

    always_ff @(posedge clk_50m or negedge rst) begin
        if (!rst) begin
            pause_m    <= 1'b0;
            pause_s    <= 1'b0;
            speed_m    <= '0;
            speed_s    <= '0;
            speed_prev <= '0;
        end else begin
            pause_m    <= bus.pause;
            pause_s    <= pause_m;
            speed_m    <= bus.speed;
            speed_s    <= speed_m;
            speed_prev <= speed_s;
        end
    end

    assign speed_chg  = (speed_s != speed_prev);
    assign bus.paused = pause_s;

    // ------------------------------------------------------------------
    // Per-channel divider
    // ------------------------------------------------------------------
    logic [NUM_CH-1:0] tick_v;
    logic [NUM_CH-1:0] clk_v;

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        localparam logic [CNT_W-1:0] DIV    = DIV_VEC[g*CNT_W +: CNT_W];
        localparam bit               SCALED = SPEED_MASK[g];
        localparam bit               FREEZE = PAUSE_MASK[g];

        logic [CNT_W-1:0] div_shift;
        logic [CNT_W-1:0] div_eff;
        logic [CNT_W-1:0] cnt;
        logic             tick_r;
        logic             clk_r;

        // A large shift can collapse the divisor to zero; clamp to 1 so the
        // channel degenerates to a tick on every cycle instead of stalling.
        assign div_shift = SCALED ? (DIV >> speed_s) : DIV;
        assign div_eff   = (div_shift == '0) ? CNT_ONE : div_shift;

        always_ff @(posedge clk_50m or negedge rst) begin
            if (!rst) begin
                cnt    <= '0;
                tick_r <= 1'b0;
                clk_r  <= 1'b0;
            end else if (SCALED && speed_chg) begin
                // Restart the period at the new rate; the old count may lie
                // beyond the new terminal value. Takes precedence over pause.
                cnt    <= '0;
                tick_r <= 1'b0;
            end else if (FREEZE && pause_s) begin
                tick_r <= 1'b0;
            end else if (cnt == div_eff - CNT_ONE) begin
                cnt    <= '0;
                tick_r <= 1'b1;
                clk_r  <= ~clk_r;
            end else begin
                cnt    <= cnt + CNT_ONE;
                tick_r <= 1'b0;
            end
        end

        assign tick_v[g] = tick_r;
        assign clk_v[g]  = clk_r;
    end

    assign bus.tick    = tick_v;
    assign bus.clk_out = clk_v;

endmodule

// File: tb/tb_tick_gen_multi.sv
// tb/tb_tick_gen_multi.sv - scoreboard bench for tick_gen_multi

module tb_tick_gen_multi;

    localparam int NUM_CH  = 3;
    localparam int CNT_W   = 8;
    localparam int SPEED_W = 2;

    logic clk_50m = 1'b0;
    logic rst     = 1'b0;

    always #5 clk_50m = ~clk_50m;

    tick_gen_multi_if #(.NUM_CH(NUM_CH), .SPEED_W(SPEED_W)) bus ();

    tick_gen_multi #(
        .NUM_CH     (NUM_CH),
        .CNT_W      (CNT_W),
        .SPEED_W    (SPEED_W),
        .DIV_VEC    ({8'd8, 8'd5, 8'd1}),
        .SPEED_MASK (3'b100),
        .PAUSE_MASK (3'b110)
    ) dut (
        .clk_50m (clk_50m),
        .rst     (rst),
        .bus     (bus)
    );

    typedef struct {
        int   cyc;
        logic clk;
    } exp_t;

    exp_t exp_q1[$];
    exp_t exp_q2[$];

    int   tests   = 0;
    int   fails   = 0;
    int   cyc     = 0;
    int   ch0_bad = 0;
    logic par1    = 1'b0;
    logic par2    = 1'b0;

    // cyc = number of rising edges since reset was released
    always @(posedge clk_50m or negedge rst) begin
        if (!rst) cyc <= 0;
        else      cyc <= cyc + 1;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic mon(input int ch, input logic t, input logic c);
        exp_t e;
        int   n;
        if (t !== 1'b1) return;
        n = (ch == 1) ? exp_q1.size() : exp_q2.size();
        if (n == 0) begin
            tests++;
            fails++;
            $display("FAIL ch%0d tick: unexpected tick at cycle %0d, none expected", ch, cyc);
            return;
        end
        if (ch == 1) e = exp_q1.pop_front();
        else         e = exp_q2.pop_front();
        check($sformatf("ch%0d tick cycle", ch), cyc, e.cyc);
        check($sformatf("ch%0d clk_out", ch), {31'd0, c}, {31'd0, e.clk});
    endtask

    // Monitor: samples on the falling edge, independent of the stimulus.
    always @(negedge clk_50m) begin
        if (rst === 1'b1) begin
            if (cyc >= 1 && (bus.tick[0] !== 1'b1 || bus.clk_out[0] !== cyc[0]))
                ch0_bad++;
            mon(1, bus.tick[1], bus.clk_out[1]);
            mon(2, bus.tick[2], bus.clk_out[2]);
        end
    end

    task automatic push(input int ch, input int c);
        exp_t e;
        e.cyc = c;
        if (ch == 1) begin
            par1  = ~par1;
            e.clk = par1;
            exp_q1.push_back(e);
        end else begin
            par2  = ~par2;
            e.clk = par2;
            exp_q2.push_back(e);
        end
    endtask

    task automatic push_range(input int ch, input int first, input int last, input int step);
        for (int c = first; c <= last; c += step) push(ch, c);
    endtask

    // Stimulus acts 1 time unit after the falling edge, after the monitor.
    task automatic step_to(input int c);
        while (cyc < c) begin
            @(negedge clk_50m);
            #1;
        end
    endtask

    task automatic drain(input string tag);
        check({tag, " ch1 ticks outstanding"}, exp_q1.size(), 0);
        check({tag, " ch2 ticks outstanding"}, exp_q2.size(), 0);
        check({tag, " ch0 bad cycles"}, ch0_bad, 0);
    endtask

    initial begin
        #100000;
        tests++;
        fails++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        bus.pause = 1'b0;
        bus.speed = 2'd0;
        repeat (3) @(negedge clk_50m);
        #1;
        check("reset tick", {29'd0, bus.tick}, 0);
        check("reset clk_out", {29'd0, bus.clk_out}, 0);
        check("reset paused", {31'd0, bus.paused}, 0);
        rst = 1'b1;

        // Free run, speed 0
        push_range(1, 5, 40, 5);
        push_range(2, 8, 40, 8);
        step_to(42);
        drain("run");

        // speed 2: ch2 restarts at cycle 45, divisor 2
        bus.speed = 2'd2;
        push_range(1, 45, 60, 5);
        push_range(2, 47, 61, 2);
        step_to(62);
        drain("speed2");

        // speed 3: divisor 8>>3 = 1
        bus.speed = 2'd3;
        push_range(1, 65, 70, 5);
        push(2, 63);
        push_range(2, 66, 72, 1);
        step_to(72);
        drain("speed3");

        // back to speed 0, then 0->1 when cnt[2]=5 suppresses the tick at 83
        bus.speed = 2'd0;
        push_range(1, 75, 95, 5);
        push(2, 73);
        push(2, 74);
        step_to(80);
        bus.speed = 2'd1;
        push_range(2, 87, 95, 4);
        step_to(96);
        drain("speed_chg");

        // pause with cnt[1]=3: edges 101..112 frozen
        push(1, 100);
        push(2, 99);
        step_to(98);
        bus.pause = 1'b1;
        step_to(99);
        check("paused before sync", {31'd0, bus.paused}, 0);
        step_to(100);
        check("paused after sync", {31'd0, bus.paused}, 1);
        step_to(105);
        check("ch1 clk_out frozen", {31'd0, bus.clk_out[1]}, {31'd0, par1});
        check("ch2 clk_out frozen", {31'd0, bus.clk_out[2]}, {31'd0, par2});
        step_to(110);
        bus.pause = 1'b0;
        step_to(112);
        check("paused released", {31'd0, bus.paused}, 0);
        push(1, 117);
        push(1, 122);
        push_range(2, 115, 123, 4);
        step_to(124);
        drain("pause");

        // pause and speed 1->0 together: ch2 cleared at 127, then frozen
        bus.pause = 1'b1;
        bus.speed = 2'd0;
        push_range(1, 137, 147, 5);
        push(2, 144);
        step_to(126);
        check("paused combined", {31'd0, bus.paused}, 1);
        step_to(134);
        bus.pause = 1'b0;
        step_to(136);
        check("paused combined release", {31'd0, bus.paused}, 0);
        step_to(150);
        drain("pause_speed");

        // asynchronous reset between clock edges
        #2;
        rst = 1'b0;
        #1;
        check("async reset tick", {29'd0, bus.tick}, 0);
        check("async reset clk_out", {29'd0, bus.clk_out}, 0);
        check("async reset paused", {31'd0, bus.paused}, 0);
        repeat (2) @(negedge clk_50m);
        #1;
        par1 = 1'b0;
        par2 = 1'b0;
        rst  = 1'b1;
        push(1, 5);
        push(1, 10);
        push(2, 8);
        step_to(12);
        drain("after reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
